// File: rtl/serv_seq_ctrl.sv
// Bit-serial instruction sequencer: fetch handshake, INIT/MEMWAIT/EXEC/TRAP passes
// and the count strobes consumed by the serial PC/control datapath.
module serv_seq_ctrl #(
  parameter int W = 1
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_ibus_ack,
  input  logic i_two_stage,
  input  logic i_mem_op,
  input  logic i_trap_req,
  input  logic i_dbus_ack,
  output logic o_ibus_cyc,
  output logic o_dbus_cyc,
  output logic o_cnt_en,
  output logic o_init,
  output logic o_pc_en,
  output logic o_trap,
  output logic o_cnt0,
  output logic o_cnt03,
  output logic o_cnt12to31,
  output logic o_cnt_done
);

  localparam int LW = (W == 4) ? 3 : 5;

  typedef enum logic [2:0] {
    FETCH,
    INIT,
    MEMWAIT,
    EXEC,
    TRAP
  } state_t;

  state_t        state;
  logic [LW-1:0] cnt;
  logic          mem_pend;
  logic [5:0]    pos;

  // 2**LW chunks of W bits always span 32 bits, so the counter wraps by itself
  assign pos = 6'(cnt) * 6'(W);

  always_comb begin
    o_cnt_en    = (state == INIT) || (state == EXEC) || (state == TRAP);
    o_init      = (state == INIT);
    o_pc_en     = (state == EXEC) || (state == TRAP);
    o_trap      = (state == TRAP);
    o_cnt0      = o_cnt_en && (pos == 6'd0);
    o_cnt03     = o_cnt_en && (pos < 6'd4);
    o_cnt12to31 = o_cnt_en && (pos >= 6'd12);
    o_cnt_done  = o_cnt_en && (pos == 6'(32 - W));
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= FETCH;
      cnt        <= '0;
      mem_pend   <= 1'b0;
      o_ibus_cyc <= 1'b0;
      o_dbus_cyc <= 1'b0;
    end else begin
      if (o_cnt_en) begin
        cnt <= cnt + LW'(1);
      end
      case (state)
        FETCH: begin
          if (o_ibus_cyc && i_ibus_ack) begin
            o_ibus_cyc <= 1'b0;
            mem_pend   <= i_mem_op;
            if (i_trap_req) begin
              state <= TRAP;
            end else if (i_two_stage) begin
              state <= INIT;
            end else begin
              state <= EXEC;
            end
          end else begin
            o_ibus_cyc <= 1'b1;
          end
        end
        INIT: begin
          if (o_cnt_done) begin
            if (i_trap_req) begin
              state    <= TRAP;
              mem_pend <= 1'b0;
            end else if (mem_pend) begin
              state      <= MEMWAIT;
              o_dbus_cyc <= 1'b1;
            end else begin
              state <= EXEC;
            end
          end
        end
        MEMWAIT: begin
          cnt <= '0;
          if (i_dbus_ack) begin
            o_dbus_cyc <= 1'b0;
            mem_pend   <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC, TRAP: begin
          if (o_cnt_done) begin
            state      <= FETCH;
            o_ibus_cyc <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_seq_ctrl.sv
// Bench for serv_seq_ctrl: W=1 and W=4 instances driven in lockstep, checked every
// cycle against a pass/beat model, plus directed scenarios with literal expectations.
module tb_serv_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ibus_ack = 1'b0, two = 1'b0, mem = 1'b0, trap = 1'b0, dbus_ack = 1'b0;

  logic ibus_cyc [2];
  logic dbus_cyc [2];
  logic cnt_en   [2];
  logic init     [2];
  logic pc_en    [2];
  logic trp      [2];
  logic cnt0     [2];
  logic cnt03    [2];
  logic cnt12    [2];
  logic done     [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serv_seq_ctrl #(.W(1)) u_dut1 (
    .clk(clk), .i_rst(rst), .i_ibus_ack(ibus_ack), .i_two_stage(two), .i_mem_op(mem),
    .i_trap_req(trap), .i_dbus_ack(dbus_ack), .o_ibus_cyc(ibus_cyc[0]),
    .o_dbus_cyc(dbus_cyc[0]), .o_cnt_en(cnt_en[0]), .o_init(init[0]), .o_pc_en(pc_en[0]),
    .o_trap(trp[0]), .o_cnt0(cnt0[0]), .o_cnt03(cnt03[0]), .o_cnt12to31(cnt12[0]),
    .o_cnt_done(done[0])
  );

  serv_seq_ctrl #(.W(4)) u_dut4 (
    .clk(clk), .i_rst(rst), .i_ibus_ack(ibus_ack), .i_two_stage(two), .i_mem_op(mem),
    .i_trap_req(trap), .i_dbus_ack(dbus_ack), .o_ibus_cyc(ibus_cyc[1]),
    .o_dbus_cyc(dbus_cyc[1]), .o_cnt_en(cnt_en[1]), .o_init(init[1]), .o_pc_en(pc_en[1]),
    .o_trap(trp[1]), .o_cnt0(cnt0[1]), .o_cnt03(cnt03[1]), .o_cnt12to31(cnt12[1]),
    .o_cnt_done(done[1])
  );

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wof(input int j);
    return (j == 0) ? 1 : 4;
  endfunction

  // Model: which pass is running and which beat of it; index 0 is W=1, index 1 is W=4
  localparam int PF = 0, PI = 1, PM = 2, PE = 3, PT = 4;
  int   ph [2];
  int   bt [2];
  logic mib [2];
  logic mdb [2];
  logic mpend [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 2; j++) begin
        ph[j] <= PF; bt[j] <= 0; mib[j] <= 1'b0; mdb[j] <= 1'b0; mpend[j] <= 1'b0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        case (ph[j])
          PF: begin
            if (mib[j] && ibus_ack) begin
              mib[j] <= 1'b0;
              mpend[j] <= mem;
              bt[j] <= 0;
              ph[j] <= trap ? PT : (two ? PI : PE);
            end else begin
              mib[j] <= 1'b1;
            end
          end
          PI: begin
            if (bt[j] == 32 / wof(j) - 1) begin
              bt[j] <= 0;
              if (trap) ph[j] <= PT;
              else if (mpend[j]) begin ph[j] <= PM; mdb[j] <= 1'b1; end
              else ph[j] <= PE;
            end else begin
              bt[j] <= bt[j] + 1;
            end
          end
          PM: begin
            if (dbus_ack) begin
              mdb[j] <= 1'b0; mpend[j] <= 1'b0; ph[j] <= PE;
            end
          end
          default: begin
            if (bt[j] == 32 / wof(j) - 1) begin
              bt[j] <= 0; ph[j] <= PF; mib[j] <= 1'b1;
            end else begin
              bt[j] <= bt[j] + 1;
            end
          end
        endcase
      end
    end
  end

  logic cact;
  int   cpos;
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      cact = (ph[j] == PI) || (ph[j] == PE) || (ph[j] == PT);
      cpos = bt[j] * wof(j);
      chk($sformatf("w%0d_ibus_cyc", wof(j)), ibus_cyc[j], mib[j]);
      chk($sformatf("w%0d_dbus_cyc", wof(j)), dbus_cyc[j], mdb[j]);
      chk($sformatf("w%0d_cnt_en", wof(j)), cnt_en[j], cact);
      chk($sformatf("w%0d_init", wof(j)), init[j], ph[j] == PI);
      chk($sformatf("w%0d_pc_en", wof(j)), pc_en[j], (ph[j] == PE) || (ph[j] == PT));
      chk($sformatf("w%0d_trap", wof(j)), trp[j], ph[j] == PT);
      chk($sformatf("w%0d_cnt0", wof(j)), cnt0[j], cact && cpos == 0);
      chk($sformatf("w%0d_cnt03", wof(j)), cnt03[j], cact && cpos < 4);
      chk($sformatf("w%0d_cnt12to31", wof(j)), cnt12[j], cact && cpos >= 12);
      chk($sformatf("w%0d_cnt_done", wof(j)), done[j], cact && cpos == 32 - wof(j));
      chk($sformatf("w%0d_bus_excl", wof(j)),
          (pc_en[j] | cnt_en[j]) & (ibus_cyc[j] | dbus_cyc[j]), 1'b0);
    end
  end

  task automatic fetch(input int sel, input logic t2, input logic m, input logic tr);
    int guard = 0;
    while (ibus_cyc[sel] !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("fetch_wait", ibus_cyc[sel], 1'b1);
    ibus_ack = 1'b1; two = t2; mem = m; trap = tr;
    @(negedge clk);
    ibus_ack = 1'b0; two = 1'b0; mem = 1'b0; trap = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ibus_cyc", ibus_cyc[0], 1'b0);
    chk("rst_pc_en", pc_en[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_ibus_cyc", ibus_cyc[0], 1'b1);

    // W=1 single-stage pass
    fetch(0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      chk("a_pc_en", pc_en[0], 1'b1);
      chk("a_cnt0", cnt0[0], i == 0);
      chk("a_cnt03", cnt03[0], i < 4);
      chk("a_cnt12to31", cnt12[0], i >= 12);
      chk("a_cnt_done", done[0], i == 31);
      @(negedge clk);
    end
    chk("a_ibus_after", ibus_cyc[0], 1'b1);
    chk("a_pc_en_after", pc_en[0], 1'b0);

    // W=4 two-stage load with a 5-cycle data bus wait
    pulse_reset();
    fetch(1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("b_init", init[1], 1'b1);
      chk("b_pc_en_init", pc_en[1], 1'b0);
      @(negedge clk);
    end
    for (int h = 0; h < 5; h++) begin
      chk("b_dbus_cyc", dbus_cyc[1], 1'b1);
      chk("b_cnt_en_wait", cnt_en[1], 1'b0);
      if (h == 4) dbus_ack = 1'b1;
      @(negedge clk);
    end
    dbus_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("b_pc_en", pc_en[1], 1'b1);
      chk("b_cnt03", cnt03[1], i == 0);
      chk("b_cnt12to31", cnt12[1], i >= 3);
      chk("b_dbus_low", dbus_cyc[1], 1'b0);
      @(negedge clk);
    end
    chk("b_ibus_after", ibus_cyc[1], 1'b1);

    // W=4 trap at fetch wins over two-stage
    pulse_reset();
    fetch(1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("c_trap", trp[1], 1'b1);
      chk("c_pc_en", pc_en[1], 1'b1);
      chk("c_no_init", init[1], 1'b0);
      @(negedge clk);
    end
    chk("c_ibus_after", ibus_cyc[1], 1'b1);

    // W=4 trap raised on the last INIT beat of a load
    pulse_reset();
    fetch(1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("d_init", init[1], 1'b1);
      if (i == 7) begin
        chk("d_done", done[1], 1'b1);
        trap = 1'b1;
      end
      @(negedge clk);
    end
    trap = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("d_trap", trp[1], 1'b1);
      chk("d_no_dbus", dbus_cyc[1], 1'b0);
      @(negedge clk);
    end

    // W=1 stray acks during INIT and EXEC
    pulse_reset();
    fetch(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      chk("e_init", init[0], 1'b1);
      chk("e_init_done", done[0], i == 31);
      ibus_ack = (i == 5);
      @(negedge clk);
    end
    ibus_ack = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("e_pc_en", pc_en[0], 1'b1);
      chk("e_cnt0", cnt0[0], i == 0);
      chk("e_exec_done", done[0], i == 31);
      dbus_ack = (i == 3);
      @(negedge clk);
    end
    dbus_ack = 1'b0;
    chk("e_ibus_after", ibus_cyc[0], 1'b1);

    // W=1 asynchronous reset mid-EXEC
    pulse_reset();
    fetch(0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("f_exec_before", pc_en[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("f_rst_ibus", ibus_cyc[0], 1'b0);
    chk("f_rst_pc_en", pc_en[0], 1'b0);
    chk("f_rst_cnt_en", cnt_en[0], 1'b0);
    chk("f_rst_cnt12", cnt12[0], 1'b0);
    chk("f_rst_dbus", dbus_cyc[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("f_release_ibus", ibus_cyc[0], 1'b1);
    chk("f_release_pc_en", pc_en[0], 1'b0);
    fetch(0, 1'b0, 1'b0, 1'b0);
    chk("f_restart_cnt0", cnt0[0], 1'b1);
    chk("f_restart_pc_en", pc_en[0], 1'b1);

    // randomized traffic, occasional resets
    for (int c = 0; c < 4000; c++) begin
      ibus_ack = 1'($urandom_range(0, 1));
      dbus_ack = ($urandom_range(0, 3) == 0);
      two      = 1'($urandom_range(0, 1));
      mem      = 1'($urandom_range(0, 1));
      trap     = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    rst = 1'b0; ibus_ack = 1'b0; dbus_ack = 1'b0; two = 1'b0; mem = 1'b0; trap = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
